// File: rtl/led_pattern_recorder.sv
// LED pattern recorder: arms for ARM_TICKS ticks, then captures sw once per tick into a
// DEPTH-step memory until stopped or full. Optional build macro REC_DEDUP_EN skips repeated steps.
module led_pattern_recorder #(
  parameter int DEPTH     = 44,
  parameter int ARM_TICKS = 20
) (
  input  logic       clk_01hz,
  input  logic       reset,
  input  logic       rec_start,
  input  logic       rec_stop,
  input  logic [9:0] sw,
  input  logic [5:0] rd_addr,
  output logic [9:0] rd_data,
  output logic [5:0] length,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic [3:0] take_count,
  output logic [9:0] mon_leds
);

  typedef enum logic [1:0] {IDLE, ARM, REC, DONE} state_t;

  localparam logic [5:0] ARM_LAST   = 6'(ARM_TICKS - 1);
  localparam logic [5:0] DEPTH_LAST = 6'(DEPTH - 1);

  state_t     state, state_next;
  logic [5:0] arm_cnt;
  logic [5:0] wr_ptr;
  logic [9:0] last_sw;
  logic       do_write;
  logic       capture_ok;
  logic [9:0] mem [0:DEPTH-1];

`ifdef REC_DEDUP_EN
  assign capture_ok = (wr_ptr == 6'd0) || (sw != last_sw);
`else
  assign capture_ok = 1'b1;
`endif

  always_ff @(posedge clk_01hz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stop wins over capture; a write into the last slot ends the take as full.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    case (state)
      IDLE: if (rec_start) state_next = ARM;
      ARM: begin
        if (rec_stop)                 state_next = IDLE;
        else if (arm_cnt == ARM_LAST) state_next = REC;
      end
      REC: begin
        if (rec_stop) begin
          state_next = DONE;
        end else if (capture_ok) begin
          do_write = 1'b1;
          if (wr_ptr == DEPTH_LAST) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_01hz or posedge reset) begin
    if (reset) begin
      arm_cnt    <= '0;
      wr_ptr     <= '0;
      length     <= '0;
      full       <= 1'b0;
      take_count <= '0;
      last_sw    <= '0;
    end else begin
      if (state == IDLE && rec_start) begin
        arm_cnt <= '0;
        wr_ptr  <= '0;
        length  <= '0;
        full    <= 1'b0;
      end
      if (state == ARM) arm_cnt <= arm_cnt + 6'd1;
      if (do_write) begin
        wr_ptr  <= wr_ptr + 6'd1;
        length  <= wr_ptr + 6'd1;
        last_sw <= sw;
        if (wr_ptr == DEPTH_LAST) full <= 1'b1;
      end
      // Counted on entry to DONE so the digit changes together with the done pulse.
      if (state == REC && state_next == DONE)
        take_count <= (take_count == 4'd9) ? 4'd0 : take_count + 4'd1;
    end
  end

  always_ff @(posedge clk_01hz) begin
    if (do_write) mem[wr_ptr] <= sw;
  end

  assign rd_data  = (rd_addr < length) ? mem[rd_addr] : 10'b0;
  assign busy     = (state == ARM) || (state == REC);
  assign done     = (state == DONE);
  assign mon_leds = (state == REC) ? sw : 10'b0;

endmodule
